// File: rtl/sync_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_ctrl
// Purpose  : Control and pointer stage for a synchronous FIFO built around an
//            external dual-port register-array memory with a 1-cycle
//            registered read port. The stage accepts push/pop requests, drives
//            the memory write port and read address, and tracks occupancy and
//            full/empty status. It also re-times the memory read data into a
//            valid-qualified output.
// Ports    : clk, rst_n             - clock, synchronous active-low reset
//            wr_en, wr_data, full   - push side
//            rd_en, rd_data,
//            rd_valid, empty        - pop side (rd_data valid 1 cycle after pop)
//            count                  - occupancy 0..DEPTH
//            overflow, underflow    - sticky error flags, cleared by reset
//            mem_we, mem_waddr,
//            mem_wdata, mem_raddr,
//            mem_rdata              - memory interface
//            almost_full,
//            almost_empty           - threshold flags (optional)
// Options  : define SYNC_FIFO_ALMOST_FLAGS_EN to enable almost_full and
//            almost_empty. When it is undefined, both outputs are tied low.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  output logic                       full,
  input  logic                       rd_en,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       rd_valid,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow,
  output logic                       mem_we,
  output logic [$clog2(DEPTH)-1:0]   mem_waddr,
  output logic [DATA_WIDTH-1:0]      mem_wdata,
  output logic [$clog2(DEPTH)-1:0]   mem_raddr,
  input  logic [DATA_WIDTH-1:0]      mem_rdata,
  output logic                       almost_full,
  output logic                       almost_empty
);

  localparam int                c_AW       = $clog2(DEPTH);
  localparam int                c_CW       = $clog2(DEPTH + 1);
  localparam logic [c_CW-1:0]   c_FULL_CNT = c_CW'(DEPTH);
  localparam logic [c_AW-1:0]   c_PTR_ONE  = c_AW'(1);
  localparam logic [c_CW-1:0]   c_CNT_ONE  = c_CW'(1);

  // Elaboration-time parameter sanity checks.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_ctrl: DEPTH must be a power of two and at least 2");
  end
  if (AF_LEVEL < 0 || AF_LEVEL > DEPTH || AE_LEVEL < 0 || AE_LEVEL > DEPTH) begin : g_bad_levels
    $error("sync_fifo_ctrl: AF_LEVEL and AE_LEVEL must lie in 0..DEPTH");
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [c_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_CW-1:0] count_q, count_d;
  logic            rd_valid_q, rd_valid_d;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;

  logic            w_full;
  logic            w_empty;
  logic            w_push_ok;
  logic            w_pop_ok;

  // Status comes only from registered count. A pop in the same cycle does not
  // make room for a push while full, and a push does not make data for a pop
  // while empty.
  assign w_full    = (count_q == c_FULL_CNT);
  assign w_empty   = (count_q == '0);
  assign w_push_ok = wr_en & ~w_full;
  assign w_pop_ok  = rd_en & ~w_empty;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_valid_d  = w_pop_ok;
    overflow_d  = overflow_q  | (wr_en & w_full);
    underflow_d = underflow_q | (rd_en & w_empty);

    // DEPTH is a power of two, so pointers wrap DEPTH-1 -> 0 by overflow.
    if (w_push_ok) begin
      wr_ptr_d = wr_ptr_q + c_PTR_ONE;
    end
    if (w_pop_ok) begin
      rd_ptr_d = rd_ptr_q + c_PTR_ONE;
    end

    unique case ({w_push_ok, w_pop_ok})
      2'b10:   count_d = count_q + c_CNT_ONE;
      2'b01:   count_d = count_q - c_CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // --------------------------------------------------------------------------
  // Memory interface
  // --------------------------------------------------------------------------
  // The memory samples mem_raddr at the same edge where rd_valid_q captures
  // pop_ok. As a result, mem_rdata and rd_valid line up in the next cycle.
  assign mem_we    = w_push_ok;
  assign mem_waddr = wr_ptr_q;
  assign mem_wdata = wr_data;
  assign mem_raddr = rd_ptr_q;

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign rd_data   = mem_rdata;
  assign rd_valid  = rd_valid_q;
  assign full      = w_full;
  assign empty     = w_empty;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

`ifdef SYNC_FIFO_ALMOST_FLAGS_EN
  localparam logic [c_CW-1:0] c_AF_CNT = c_CW'(AF_LEVEL);
  localparam logic [c_CW-1:0] c_AE_CNT = c_CW'(AE_LEVEL);

  assign almost_full  = (count_q >= c_AF_CNT);
  assign almost_empty = (count_q <= c_AE_CNT);
`else
  assign almost_full  = 1'b0;
  assign almost_empty = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_ctrl
// Purpose  : Self-checking bench for sync_fifo_ctrl. A behavioural
//            registered-read memory is attached to the memory port. A
//            reference queue model predicts acceptance, occupancy, flags and
//            pop data. Popped words are moved to an expect queue and compared
//            against rd_data when rd_valid rises.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_ctrl;

  localparam int DW = 16;
  localparam int DP = 16;
  localparam int AW = $clog2(DP);
  localparam int CW = $clog2(DP + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic          full, empty, rd_valid, overflow, underflow;
  logic          almost_full, almost_empty;
  logic [DW-1:0] rd_data;
  logic [CW-1:0] count;
  logic          mem_we;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  logic [DW-1:0] mem [DP];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [DW-1:0] data_q[$];
  logic [DW-1:0] exp_q[$];
  int            m_count = 0;
  bit            m_ovf = 0;
  bit            m_unf = 0;
  bit            m_valid = 0;

`ifdef SYNC_FIFO_ALMOST_FLAGS_EN
  localparam bit ALMOST_ON = 1'b1;
`else
  localparam bit ALMOST_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  // Dual-port register array with a registered read port
  always @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    mem_rdata <= mem[mem_raddr];
  end

  sync_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .full         (full),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .mem_we       (mem_we),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .mem_raddr    (mem_raddr),
    .mem_rdata    (mem_rdata),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  // One clock cycle. Drives the inputs, checks the pre-edge status against the
  // model, advances the model and the DUT, and then scoreboards the outputs.
  task automatic step(input logic i_rst, input logic i_we,
                      input logic [DW-1:0] i_wd, input logic i_re);
    bit            push_ok;
    bit            pop_ok;
    logic [DW-1:0] exp;
    rst_n   = i_rst;
    wr_en   = i_we;
    wr_data = i_wd;
    rd_en   = i_re;
    #1;
    if (i_rst) begin
      n_cmp++;
      if (count !== CW'(m_count) || full !== (m_count == DP) || empty !== (m_count == 0)) begin
        n_err++;
        $display("FAIL pre_status: count=%0d full=%b empty=%b, required count=%0d full=%b empty=%b",
                 count, full, empty, m_count, (m_count == DP), (m_count == 0));
      end
    end
    push_ok = i_we && (m_count < DP);
    pop_ok  = i_re && (m_count > 0);
    @(posedge clk);
    if (!i_rst) begin
      data_q.delete();
      exp_q.delete();
      m_count = 0;
      m_ovf   = 0;
      m_unf   = 0;
      m_valid = 0;
    end else begin
      if (i_we && m_count == DP) m_ovf = 1;
      if (i_re && m_count == 0)  m_unf = 1;
      if (push_ok) data_q.push_back(i_wd);
      if (pop_ok)  exp_q.push_back(data_q.pop_front());
      m_count = m_count + int'(push_ok) - int'(pop_ok);
      m_valid = pop_ok;
    end
    #1;
    n_cmp++;
    if (rd_valid !== m_valid) begin
      n_err++;
      $display("FAIL rd_valid: got %b, required %b", rd_valid, m_valid);
    end
    if (m_valid) begin
      exp = exp_q.pop_front();
      n_cmp++;
      if (rd_data !== exp) begin
        n_err++;
        $display("FAIL rd_data: got %h, required %h", rd_data, exp);
      end
    end
    n_cmp++;
    if (overflow !== m_ovf || underflow !== m_unf || count !== CW'(m_count)) begin
      n_err++;
      $display("FAIL post_state: ovf=%b unf=%b count=%0d, required ovf=%b unf=%b count=%0d",
               overflow, underflow, count, m_ovf, m_unf, m_count);
    end
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    n_cmp++;
    if (empty !== 1'b1 || full !== 1'b0 || count !== '0 || rd_valid !== 1'b0 ||
        overflow !== 1'b0 || underflow !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: empty=%b full=%b count=%0d rd_valid=%b ovf=%b unf=%b, required 1 0 0 0 0 0",
               empty, full, count, rd_valid, overflow, underflow);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= DP; i++) step(1'b1, 1'b1, DW'(i), 1'b0);
    n_cmp++;
    if (full !== 1'b1 || count !== CW'(16)) begin
      n_err++;
      $display("FAIL fill: full=%b count=%0d, required full=1 count=16", full, count);
    end
    step(1'b1, 1'b1, 16'hDEAD, 1'b0);
    n_cmp++;
    if (overflow !== 1'b1 || count !== CW'(16)) begin
      n_err++;
      $display("FAIL overflow: ovf=%b count=%0d, required ovf=1 count=16", overflow, count);
    end
  endtask

  task automatic test_drain_underflow();
    for (int i = 1; i <= DP; i++) begin
      step(1'b1, 1'b0, '0, 1'b1);
      n_cmp++;
      if (rd_valid !== 1'b1 || rd_data !== DW'(i)) begin
        n_err++;
        $display("FAIL drain_order: valid=%b data=%h, required valid=1 data=%h", rd_valid, rd_data, DW'(i));
      end
    end
    n_cmp++;
    if (empty !== 1'b1) begin
      n_err++;
      $display("FAIL drain_empty: got %b, required 1", empty);
    end
    step(1'b1, 1'b0, '0, 1'b1);
    n_cmp++;
    if (underflow !== 1'b1 || rd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL underflow: unf=%b rd_valid=%b, required unf=1 rd_valid=0", underflow, rd_valid);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, DW'(16'h5000 + i), 1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 8; i++)  step(1'b1, 1'b1, DW'(16'hA000 + i), 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, '0, 1'b1);
      n_cmp++;
      if (rd_data !== DW'(16'hA000 + i)) begin
        n_err++;
        $display("FAIL wrap_order: got %h, required %h", rd_data, DW'(16'hA000 + i));
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, DW'(16'hB000 + i), 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, DW'(16'hC000 + i), 1'b1);
      n_cmp++;
      if (count !== CW'(5)) begin
        n_err++;
        $display("FAIL simul_count: got %0d, required 5", count);
      end
    end
    for (int i = 0; i < 11; i++) step(1'b1, 1'b1, DW'(16'hD000 + i), 1'b0);
    step(1'b1, 1'b1, 16'hEEEE, 1'b1);
    n_cmp++;
    if (count !== CW'(15) || full !== 1'b0) begin
      n_err++;
      $display("FAIL full_simul: count=%0d full=%b, required count=15 full=0", count, full);
    end
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0, '0, 1'b1);
  endtask

  task automatic test_reset_midop();
    step(1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, DW'(16'h7700 + i), 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    n_cmp++;
    if (rd_valid !== 1'b0 || count !== '0 || empty !== 1'b1) begin
      n_err++;
      $display("FAIL reset_midop: rd_valid=%b count=%0d empty=%b, required 0 0 1", rd_valid, count, empty);
    end
    step(1'b1, 1'b0, '0, 1'b0);
  endtask

  task automatic test_almost_flags();
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, DW'(i), 1'b0);
    n_cmp++;
    if (almost_empty !== ALMOST_ON || almost_full !== 1'b0) begin
      n_err++;
      $display("FAIL almost_at2: ae=%b af=%b, required ae=%b af=0", almost_empty, almost_full, ALMOST_ON);
    end
    step(1'b1, 1'b1, 16'h0003, 1'b0);
    n_cmp++;
    if (almost_empty !== 1'b0) begin
      n_err++;
      $display("FAIL almost_at3: ae=%b, required 0", almost_empty);
    end
    for (int i = 3; i < 13; i++) step(1'b1, 1'b1, DW'(i), 1'b0);
    n_cmp++;
    if (almost_full !== 1'b0) begin
      n_err++;
      $display("FAIL almost_at13: af=%b, required 0", almost_full);
    end
    step(1'b1, 1'b1, 16'h000E, 1'b0);
    n_cmp++;
    if (almost_full !== ALMOST_ON || almost_empty !== 1'b0) begin
      n_err++;
      $display("FAIL almost_at14: af=%b ae=%b, required af=%b ae=0", almost_full, almost_empty, ALMOST_ON);
    end
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_drain_underflow();
    test_wrap();
    test_back_to_back();
    test_reset_midop();
    test_almost_flags();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
